uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO between a character source (ROM sequencer, CPU bus) and wb_uart_tx.
//  Lets the producer burst bytes while the serialiser drains them at baud rate.
//  Read side drives the i_wr/i_data/o_busy handshake of wb_uart_tx directly.
//  Replaces the ad-hoc index/strobe logic in the helloworld top level.
// PARAMETERS
//  LGFLEN  4  log2 of FIFO depth; depth = 2**LGFLEN entries (16 by default)
//  DW      8  data width in bits
// PORTS
//  i_clk        in   1         system clock, all logic on rising edge
//  i_reset_n    in   1         async assert, active-low reset; sync release upstream
//  i_wr         in   1         producer write strobe
//  i_data       in   DW        producer write data
//  o_full       out  1         high when fill == 2**LGFLEN
//  o_empty      out  1         high when fill == 0
//  o_fill       out  LGFLEN+1  current occupancy, 0..2**LGFLEN
//  o_overflow   out  1         sticky: a write was dropped; cleared only by reset
//  o_tx_stb     out  1         to wb_uart_tx i_wr; equals !o_empty
//  o_tx_data    out  DW        to wb_uart_tx i_data; head entry, valid while o_tx_stb
//  i_tx_busy    in   1         from wb_uart_tx o_busy
// BEHAVIOUR
//  - Reset (i_reset_n low, async): wr_ptr=rd_ptr=0, o_fill=0, o_empty=1,
//    o_full=0, o_overflow=0, o_tx_stb=0. o_tx_data is don't-care (memory not reset).
//  - Pointers are LGFLEN+1 bits and wrap modulo 2**(LGFLEN+1);
//    fill = wr_ptr - rd_ptr; memory index = pointer[LGFLEN-1:0].
//  - pop  = o_tx_stb && !i_tx_busy (same rule wb_uart_tx uses to accept a byte).
//  - push = i_wr && (!o_full || pop). A write while full with a pop in the same
//    cycle is accepted; the freed slot is reused and fill stays at max.
//  - Dropped write (i_wr && o_full && !pop): data discarded, pointers unchanged,
//    o_overflow set on the next edge and held until reset.
//  - Write at edge N: entry in memory and o_fill incremented after edge N;
//    o_tx_stb rises in cycle N+1 if the FIFO was empty (1-cycle latency, no bypass).
//  - Write into an empty FIFO never pops in the same cycle, because o_tx_stb is low.
//  - o_tx_data = mem[rd_ptr] (async read of array). It must remain stable while
//    o_tx_stb && i_tx_busy; it changes only after a pop or on the first write.
//  - push && pop together: both pointers advance, o_fill unchanged.
//  - o_full, o_empty, o_fill, o_tx_stb are registered or pure decodes of
//    registered pointers; no combinational path from i_wr or i_tx_busy to any output.
//  - Reset mid-transfer: queued bytes are lost; the byte already inside
//    wb_uart_tx is not affected by this block.
// TESTING
//  1 Reset, then write 0x48 once with i_tx_busy=0 -> o_tx_stb high one cycle
//    later with o_tx_data=0x48; pops on that cycle; o_empty=1 again next cycle.
//  2 Hold i_tx_busy=1 and write 16 bytes 0x00..0x0F -> o_full=1, o_fill=16;
//    17th write 0xAA dropped, o_overflow=1; release busy -> 0x00..0x0F drain in order.
//  3 FIFO full with i_tx_busy=0 and i_wr=1 on the same cycle -> pop and push
//    both occur, o_fill stays 16, o_overflow stays 0.
//  4 Write 40 bytes with busy pulsed 1-of-3 cycles -> all 40 bytes out in order
//    (pointer wrap); o_fill never exceeds 16; o_overflow stays 0.
//  5 Load 5 bytes, assert i_reset_n=0 mid-drain -> o_fill=0, o_tx_stb=0,
//    o_overflow=0 immediately (async); after release, next written byte is the
//    first one presented.
//  6 Integration with wb_uart_tx (CLOCKS_PER_BAUD=868): push "Hello, World!\r\n"
//    in one burst -> line decoder captures exactly that 15-byte string.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding wb_uart_tx. The producer can burst up to 2**LGFLEN bytes
// while the read side follows the serialiser's i_wr/o_busy handshake.
// Pointers carry one extra bit so that full and empty can be told apart.
module uart_tx_fifo #(
   parameter int LGFLEN = 4,
   parameter int DW     = 8
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_wr,
   input  logic [DW-1:0]     i_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [LGFLEN:0]   o_fill,
   output logic              o_overflow,
   output logic              o_tx_stb,
   output logic [DW-1:0]     o_tx_data,
   input  logic              i_tx_busy
);

   localparam int DEPTH = 1 << LGFLEN;
   localparam logic [LGFLEN:0] PTR_ONE = 1;

   logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
   logic [LGFLEN:0] rd_ptr_q, rd_ptr_d;
   logic [LGFLEN:0] fill;
   logic            ovf_q, ovf_d;
   logic            push, pop;
   logic [DW-1:0]   mem_q [DEPTH];

   // Status decodes depend only on the registered pointers and sticky flag.
   always_comb begin
      fill       = wr_ptr_q - rd_ptr_q;
      o_fill     = fill;
      o_full     = fill[LGFLEN];          // fill never exceeds DEPTH
      o_empty    = (fill == '0);
      o_tx_stb   = !o_empty;
      o_overflow = ovf_q;
      o_tx_data  = mem_q[rd_ptr_q[LGFLEN-1:0]];
   end

   // Handshake: a pop frees a slot, so a write while full is still taken
   // if the serialiser accepts the head byte in the same cycle.
   always_comb begin
      pop      = o_tx_stb && !i_tx_busy;
      push     = i_wr && (!o_full || pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (i_wr && o_full && !pop) ovf_d = 1'b1;
   end

   // Pointer and overflow state; cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents are don't-care after reset so it has none.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q[LGFLEN-1:0]] <= i_data;
   end

endmodule
